// File: rtl/trap_vector_unit.sv
`default_nettype none
// ============================================================================
// Module      : trap_vector_unit
// Description : Trap controller with a writable trap-vector base register
//               (direct or vectored mode). It captures the exception PC,
//               cause and value, and sequences the trap-entry, handler and
//               return redirects to fetch. A trap raised while a handler is
//               running latches a sticky double fault, and fetch is redirected
//               to a fixed handler address.
// Macro       : TRAP_COUNTER_EN - adds the saturating trap_count port/counter
// Ports       : clk, reset (sync, active-high)
//               exc_valid/exc_cause/exc_pc/exc_tval - exception request
//               mret - handler return request
//               tvec_we/tvec_wdata - vector base register write
//               tvec - base register readback (bit1 reads 0)
//               redirect_valid/redirect_pc/flush - PC redirect to fetch
//               epc/cause/tval - captured trap information
//               in_handler, double_fault - status
//               trap_count - trap-entry counter (TRAP_COUNTER_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module trap_vector_unit #(
   parameter int          XLEN       = 32,
   parameter int          CAUSE_W    = 4,
   parameter int          NUM_CAUSES = 4,
   parameter logic [31:0] RESET_BASE = 32'h00000080,
   parameter int          RESET_MODE = 1,
   parameter logic [31:0] DF_ADDR    = 32'h000000FC
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               exc_valid,
   input  logic [CAUSE_W-1:0] exc_cause,
   input  logic [XLEN-1:0]    exc_pc,
   input  logic [XLEN-1:0]    exc_tval,
   input  logic               mret,
   input  logic               tvec_we,
   input  logic [XLEN-1:0]    tvec_wdata,
   output logic [XLEN-1:0]    tvec,
   output logic               redirect_valid,
   output logic [XLEN-1:0]    redirect_pc,
   output logic               flush,
   output logic [XLEN-1:0]    epc,
   output logic [XLEN-1:0]    tval,
   output logic [CAUSE_W-1:0] cause,
   output logic               in_handler,
   output logic               double_fault
`ifdef TRAP_COUNTER_EN
   ,
   output logic [31:0]        trap_count
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TRAP    = 3'd1,
      ST_HANDLER = 3'd2,
      ST_RETURN  = 3'd3,
      ST_HALT    = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [XLEN-3:0]     r_base;
   logic                r_mode;
   logic [XLEN-1:0]     r_target;
   logic [XLEN-1:0]     r_epc;
   logic [XLEN-1:0]     r_tval;
   logic [CAUSE_W-1:0]  r_cause;
   logic                r_df;
   logic                r_df_entry;   // high only in the first HALT cycle
   logic [XLEN-1:0]     w_slot;
   logic [XLEN-1:0]     w_target;
   logic                w_trap_take;
   logic                w_df_take;
   logic                w_unused_wbit;

   // Bit 1 of the written value has no storage; it always reads back as 0.
   assign w_unused_wbit = tvec_wdata[1];

   // Causes past the dedicated slots share the single overflow slot.
   assign w_slot   = (XLEN'(exc_cause) >= XLEN'(NUM_CAUSES)) ? XLEN'(NUM_CAUSES)
                                                              : XLEN'(exc_cause);
   // Uses the base register value from before this edge, so a concurrent
   // write does not affect the trap taken in the same cycle.
   assign w_target = r_mode ? ({r_base, 2'b00} + (w_slot << 2)) : {r_base, 2'b00};

   assign w_trap_take = (r_state == ST_IDLE) && exc_valid;
   assign w_df_take   = (r_state == ST_HANDLER) && exc_valid;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (exc_valid) w_next = ST_TRAP;
         ST_TRAP:    w_next = ST_HANDLER;
         ST_HANDLER: begin
            // A nested exception wins over a simultaneous return.
            if (exc_valid)  w_next = ST_HALT;
            else if (mret)  w_next = ST_RETURN;
         end
         ST_RETURN:  w_next = ST_IDLE;
         ST_HALT:    w_next = ST_HALT;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      flush          = 1'b0;
      if (r_state == ST_TRAP) begin
         redirect_valid = 1'b1;
         redirect_pc    = r_target;
         flush          = 1'b1;
      end else if (r_state == ST_RETURN) begin
         redirect_valid = 1'b1;
         redirect_pc    = r_epc;
      end else if (r_df_entry) begin
         redirect_valid = 1'b1;
         redirect_pc    = XLEN'(DF_ADDR);
         flush          = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_base     <= RESET_BASE[XLEN-1:2];
         r_mode     <= 1'(RESET_MODE);
         r_target   <= '0;
         r_epc      <= '0;
         r_tval     <= '0;
         r_cause    <= '0;
         r_df       <= 1'b0;
         r_df_entry <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_df_entry <= w_df_take;
         if (tvec_we) begin
            r_base <= tvec_wdata[XLEN-1:2];
            r_mode <= tvec_wdata[0];
         end
         if (w_trap_take) begin
            r_target <= w_target;
            r_epc    <= exc_pc;
            r_tval   <= exc_tval;
            r_cause  <= exc_cause;
         end
         if (w_df_take) r_df <= 1'b1;
      end
   end

`ifdef TRAP_COUNTER_EN
   logic [31:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if ((w_trap_take || w_df_take) && (r_count != 32'hFFFFFFFF)) begin
         r_count <= r_count + 32'd1;
      end
   end

   assign trap_count = r_count;
`endif

   assign tvec         = {r_base, 1'b0, r_mode};
   assign epc          = r_epc;
   assign tval         = r_tval;
   assign cause        = r_cause;
   assign in_handler   = (r_state == ST_HANDLER);
   assign double_fault = r_df;

endmodule
`default_nettype wire

// File: tb/tb_trap_vector_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_vector_unit
// Description : Directed self-checking bench for trap_vector_unit with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_vector_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        exc_valid;
   logic [3:0]  exc_cause;
   logic [31:0] exc_pc;
   logic [31:0] exc_tval;
   logic        mret;
   logic        tvec_we;
   logic [31:0] tvec_wdata;
   logic [31:0] tvec;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush;
   logic [31:0] epc;
   logic [31:0] tval;
   logic [3:0]  cause;
   logic        in_handler;
   logic        double_fault;
`ifdef TRAP_COUNTER_EN
   logic [31:0] trap_count;
`endif

   int total = 0;
   int bad   = 0;

   trap_vector_unit dut (
      .clk            (clk),
      .reset          (reset),
      .exc_valid      (exc_valid),
      .exc_cause      (exc_cause),
      .exc_pc         (exc_pc),
      .exc_tval       (exc_tval),
      .mret           (mret),
      .tvec_we        (tvec_we),
      .tvec_wdata     (tvec_wdata),
      .tvec           (tvec),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .epc            (epc),
      .tval           (tval),
      .cause          (cause),
      .in_handler     (in_handler),
      .double_fault   (double_fault)
`ifdef TRAP_COUNTER_EN
      ,
      .trap_count     (trap_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      exc_valid  = 1'b0;
      mret       = 1'b0;
      tvec_we    = 1'b0;
   endtask

   initial begin
      reset = 1'b1; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
      mret = 1'b0; tvec_we = 1'b0; tvec_wdata = '0;
      tick(); tick();
      chk("rst_tvec", tvec, 32'h00000081);
      chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
      chk("rst_rpc", redirect_pc, 32'd0);
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_epc", epc, 32'd0);
      chk("rst_tval", tval, 32'd0);
      chk("rst_cause", {28'd0, cause}, 32'd0);
      chk("rst_inh", {31'd0, in_handler}, 32'd0);
      chk("rst_df", {31'd0, double_fault}, 32'd0);
`ifdef TRAP_COUNTER_EN
      chk("rst_cnt", trap_count, 32'd0);
`endif

      // Vectored trap, cause 2: 0x80 + 8
      reset = 1'b0;
      exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
      tick();
      chk("t1_rv", {31'd0, redirect_valid}, 32'd1);
      chk("t1_rpc", redirect_pc, 32'h88);
      chk("t1_flush", {31'd0, flush}, 32'd1);
      chk("t1_epc", epc, 32'h100);
      chk("t1_cause", {28'd0, cause}, 32'd2);
      chk("t1_tval", tval, 32'hDEAD);
      idle_inputs();
      tick();
      chk("t1_hnd_rv", {31'd0, redirect_valid}, 32'd0);
      chk("t1_inh", {31'd0, in_handler}, 32'd1);
      mret = 1'b1;
      tick();
      chk("t1_ret_rv", {31'd0, redirect_valid}, 32'd1);
      chk("t1_ret_rpc", redirect_pc, 32'h100);
      chk("t1_ret_flush", {31'd0, flush}, 32'd0);
      chk("t1_ret_inh", {31'd0, in_handler}, 32'd0);
      mret = 1'b0;
      tick();
      chk("t1_idle_rv", {31'd0, redirect_valid}, 32'd0);
      mret = 1'b1;
      tick();
      chk("mret_idle_rv", {31'd0, redirect_valid}, 32'd0);
      mret = 1'b0;
      tick();
      chk("mret_idle_rv2", {31'd0, redirect_valid}, 32'd0);

      // Direct mode base 0x2000
      tvec_we = 1'b1; tvec_wdata = 32'h00002000;
      tick();
      tvec_we = 1'b0;
      chk("wr_tvec", tvec, 32'h00002000);
      exc_valid = 1'b1; exc_cause = 4'd1; exc_pc = 32'h200;
      tick();
      chk("dir_rpc", redirect_pc, 32'h2000);
      chk("dir_rv", {31'd0, redirect_valid}, 32'd1);
      exc_valid = 1'b0;
      tick();
      mret = 1'b1;
      tick();
      chk("dir_ret_rpc", redirect_pc, 32'h200);
      mret = 1'b0;
      tick();

      // Vectored, bit1 written but ignored
      tvec_we = 1'b1; tvec_wdata = 32'h00002003;
      tick();
      tvec_we = 1'b0;
      chk("wr_tvec2", tvec, 32'h00002001);
      exc_valid = 1'b1; exc_cause = 4'd3; exc_pc = 32'h300;
      tick();
      chk("vec3_rpc", redirect_pc, 32'h200C);
      exc_valid = 1'b0;
      tick();
      mret = 1'b1;
      tick();
      mret = 1'b0;
      tick();

      // Cause beyond dedicated slots uses overflow slot
      exc_valid = 1'b1; exc_cause = 4'd9; exc_pc = 32'h400;
      tick();
      chk("vec9_rpc", redirect_pc, 32'h2010);
      exc_valid = 1'b0;
      tick();
      mret = 1'b1;
      tick();
      chk("vec9_ret_rv", {31'd0, redirect_valid}, 32'd1);
      // exc_valid during RETURN is ignored
      mret = 1'b0; exc_valid = 1'b1; exc_cause = 4'd0; exc_pc = 32'h666;
      tick();
      chk("ret_ign_rv", {31'd0, redirect_valid}, 32'd0);
      chk("ret_ign_epc", epc, 32'h400);
      // Concurrent base write and trap: old base used
      exc_cause = 4'd1; exc_pc = 32'h500; exc_tval = 32'h55;
      tvec_we = 1'b1; tvec_wdata = 32'h00003001;
      tick();
      chk("old_base_rpc", redirect_pc, 32'h2004);
      chk("old_base_tvec", tvec, 32'h00003001);
      idle_inputs();
      tick();
      chk("df_pre_inh", {31'd0, in_handler}, 32'd1);

      // Nested trap with simultaneous mret -> double fault
      exc_valid = 1'b1; mret = 1'b1; exc_cause = 4'd7; exc_pc = 32'h999; exc_tval = 32'h77;
      tick();
      chk("df_rv", {31'd0, redirect_valid}, 32'd1);
      chk("df_rpc", redirect_pc, 32'hFC);
      chk("df_flush", {31'd0, flush}, 32'd1);
      chk("df_flag", {31'd0, double_fault}, 32'd1);
      chk("df_epc", epc, 32'h500);
      chk("df_cause", {28'd0, cause}, 32'd1);
      chk("df_tval", tval, 32'h55);
      tick();
      chk("halt_rv1", {31'd0, redirect_valid}, 32'd0);
      idle_inputs();
      tick();
      chk("halt_rv2", {31'd0, redirect_valid}, 32'd0);
      chk("halt_df", {31'd0, double_fault}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("df_clr", {31'd0, double_fault}, 32'd0);
      chk("df_clr_tvec", tvec, 32'h00000081);

`ifdef TRAP_COUNTER_EN
      for (int i = 0; i < 3; i++) begin
         exc_valid = 1'b1; exc_cause = 4'd0; exc_pc = 32'h10 * i;
         tick();
         exc_valid = 1'b0;
         tick();
         mret = 1'b1;
         tick();
         mret = 1'b0;
         tick();
      end
      chk("cnt3", trap_count, 32'd3);
`endif

      // Reset during TRAP suppresses the following redirect
      exc_valid = 1'b1; exc_cause = 4'd0; exc_pc = 32'h700;
      tick();
      chk("pre_rst_rv", {31'd0, redirect_valid}, 32'd1);
      exc_valid = 1'b0; reset = 1'b1;
      tick();
      chk("rst_mid_rv", {31'd0, redirect_valid}, 32'd0);
      chk("rst_mid_epc", epc, 32'd0);
`ifdef TRAP_COUNTER_EN
      chk("rst_mid_cnt", trap_count, 32'd0);
`endif
      reset = 1'b0;
      tick();
      chk("post_rst_rv", {31'd0, redirect_valid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
